// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the system bus between the fetch and data masters and decodes onto six slaves.
// Latency: one grant cycle, then the slave's own latency; unmapped accesses error in the second cycle.
// Backpressure: masters hold valid until ready; a slave that never answers is cut off after `timeout` busy cycles.
// Ports: imem_* fetch master, dmem_* data master, slv_* shared slave bus (slv_rdata packs slave i at [32i+31:32i]).
module bus_arbiter #(
  parameter logic [31:0] rom_base   = 32'h0,
  parameter logic [31:0] rom_top    = 32'h80,
  parameter logic [31:0] uart_base  = 32'h1000000,
  parameter logic [31:0] uart_top   = 32'h1000004,
  parameter logic [31:0] clint_base = 32'h2000000,
  parameter logic [31:0] clint_top  = 32'h200C000,
  parameter logic [31:0] clic_base  = 32'h3000000,
  parameter logic [31:0] clic_top   = 32'h3005000,
  parameter logic [31:0] tim_base   = 32'h10000000,
  parameter logic [31:0] tim_top    = 32'h10100000,
  parameter logic [31:0] ram_base   = 32'h80000000,
  parameter logic [31:0] ram_top    = 32'h90000000,
  parameter int unsigned timeout    = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         imem_valid,
  input  logic [31:0]  imem_addr,
  output logic [31:0]  imem_rdata,
  output logic         imem_ready,
  output logic         imem_error,
  input  logic         dmem_valid,
  input  logic [31:0]  dmem_addr,
  input  logic [31:0]  dmem_wdata,
  input  logic [3:0]   dmem_wstrb,
  output logic [31:0]  dmem_rdata,
  output logic         dmem_ready,
  output logic         dmem_error,
  output logic [5:0]   slv_valid,
  output logic         slv_instr,
  output logic [31:0]  slv_addr,
  output logic [31:0]  slv_wdata,
  output logic [3:0]   slv_wstrb,
  input  logic [191:0] slv_rdata,
  input  logic [5:0]   slv_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam int CW = (timeout > 2) ? $clog2(timeout) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout - 1);

  localparam logic [31:0] BASE [6] = '{rom_base, uart_base, clint_base, clic_base, tim_base, ram_base};
  localparam logic [31:0] TOP  [6] = '{rom_top, uart_top, clint_top, clic_top, tim_top, ram_top};

  logic [1:0]    state;
  logic [2:0]    sel;
  logic [CW-1:0] cnt;
  logic          last_instr;

  logic          pick_instr;
  logic [31:0]   win_addr;
  logic          win_hit;
  logic [2:0]    win_sel;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic          done_ok;
  logic          done_to;
  logic          done_err;
  logic          done;
  logic          err_out;
  logic [31:0]   rdata_out;

  // On contention the master that did not win last time goes first.
  assign pick_instr = imem_valid & (~dmem_valid | ~last_instr);
  assign win_addr   = pick_instr ? imem_addr : dmem_addr;

  always_comb begin
    win_hit = 1'b0;
    win_sel = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (win_addr >= BASE[i] && win_addr < TOP[i]) begin
        win_hit = 1'b1;
        win_sel = 3'(i);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    slv_valid = '0;
    for (int i = 0; i < 6; i++) begin
      if (sel == 3'(i)) begin
        sel_ready    = slv_ready[i];
        sel_rdata    = slv_rdata[32*i +: 32];
        slv_valid[i] = (state == BUSY);
      end
    end
  end

  // A slave answering in the timeout cycle wins over the forced error.
  assign done_ok  = (state == BUSY) & sel_ready;
  assign done_to  = (state == BUSY) & ~sel_ready & (cnt == CNT_LAST);
  assign done_err = (state == ERR);
  assign done     = done_ok | done_to | done_err;
  assign err_out  = done_to | done_err;
  assign rdata_out = done_ok ? sel_rdata : 32'd0;

  assign imem_ready = done & slv_instr;
  assign dmem_ready = done & ~slv_instr;
  assign imem_error = err_out & slv_instr;
  assign dmem_error = err_out & ~slv_instr;
  assign imem_rdata = slv_instr ? rdata_out : 32'd0;
  assign dmem_rdata = slv_instr ? 32'd0 : rdata_out;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel        <= 3'd0;
      cnt        <= '0;
      last_instr <= 1'b1;
      slv_instr  <= 1'b0;
      slv_addr   <= 32'd0;
      slv_wdata  <= 32'd0;
      slv_wstrb  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_valid | dmem_valid) begin
            sel        <= win_sel;
            cnt        <= '0;
            last_instr <= pick_instr;
            slv_instr  <= pick_instr;
            slv_addr   <= win_addr;
            slv_wdata  <= pick_instr ? 32'd0 : dmem_wdata;
            slv_wstrb  <= pick_instr ? 4'd0 : dmem_wstrb;
            state      <= win_hit ? BUSY : ERR;
          end
        end
        BUSY: begin
          if (done_ok | done_to) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         imem_valid;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic         imem_ready;
  logic         imem_error;
  logic         dmem_valid;
  logic [31:0]  dmem_addr;
  logic [31:0]  dmem_wdata;
  logic [3:0]   dmem_wstrb;
  logic [31:0]  dmem_rdata;
  logic         dmem_ready;
  logic         dmem_error;
  logic [5:0]   slv_valid;
  logic         slv_instr;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [191:0] slv_rdata;
  logic [5:0]   slv_ready;

  bus_arbiter #(.timeout(TO)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata),
    .slv_ready(slv_ready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: address map and slave behaviour ----------------
  int unsigned map_base [6] = '{32'h0, 32'h1000000, 32'h2000000, 32'h3000000, 32'h10000000, 32'h80000000};
  int unsigned map_top  [6] = '{32'h80, 32'h1000004, 32'h200C000, 32'h3005000, 32'h10100000, 32'h90000000};

  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < 6; i++)
      if (a >= map_base[i] && a < map_top[i]) return i;
    return -1;
  endfunction

  // Bench slaves: the bottom 256 bytes of TIM never answer; page 0xA answers on the last legal cycle.
  function automatic bit ref_hung(input logic [31:0] a);
    return ref_slave(a) == 4 && a[19:8] == 12'h0;
  endfunction

  function automatic int ref_lat(input logic [31:0] a);
    return (a[11:8] == 4'hA) ? TO - 1 : 7 - int'(a[4:2]);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  resp_t q_i[$];
  resp_t q_d[$];

  function automatic resp_t ref_resp(input logic [31:0] a);
    resp_t r;
    if (ref_slave(a) < 0 || ref_hung(a)) begin r.rdata = 32'd0; r.err = 1'b1; end
    else begin r.rdata = ref_data(a); r.err = 1'b0; end
    return r;
  endfunction

  // Cycles from valid to the cycle showing ready, counting the grant cycle as 1.
  function automatic int ref_cycles(input logic [31:0] a);
    if (ref_slave(a) < 0) return 2;
    if (ref_hung(a)) return 1 + TO;
    return 2 + ref_lat(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 7);
    if (r < 6) a = map_base[r] + ($urandom % (map_top[r] - map_base[r]));
    else if (r == 6) a = ($urandom_range(0, 1) == 0) ? map_top[$urandom_range(0, 5)] : map_base[$urandom_range(1, 5)] - 1;
    else a = $urandom;
    if (r == 4 && $urandom_range(0, 3) == 0) a[19:8] = 12'h0;
    return a;
  endfunction

  // ---------------- masters ----------------
  logic [31:0] req_i_addr, req_d_addr, req_d_wdata;
  logic [3:0]  req_d_wstrb;

  task automatic drive_i(input logic [31:0] a, output int cyc);
    int n = 0;
    q_i.push_back(ref_resp(a));
    req_i_addr = a; imem_addr = a; imem_valid = 1'b1;
    do begin @(negedge clock); n++; end while (!imem_ready && n < 200);
    if (!imem_ready) begin
      total++; bad++;
      $display("FAIL imem_wait: no ready after %0d cycles, required within 200", n);
      void'(q_i.pop_back());
    end
    cyc = n;
    @(posedge clock); #1;
    imem_valid = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, output int cyc);
    int n = 0;
    q_d.push_back(ref_resp(a));
    req_d_addr = a; req_d_wdata = wd; req_d_wstrb = ws;
    dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws; dmem_valid = 1'b1;
    do begin @(negedge clock); n++; end while (!dmem_ready && n < 200);
    if (!dmem_ready) begin
      total++; bad++;
      $display("FAIL dmem_wait: no ready after %0d cycles, required within 200", n);
      void'(q_d.pop_back());
    end
    cyc = n;
    @(posedge clock); #1;
    dmem_valid = 1'b0;
  endtask

  // ---------------- slave model ----------------
  int on_cnt = 0;
  int busy_cycles = 0;
  int cur_idx = 0;
  int gcnt = 0;
  logic [7:0] glog = 8'd0;
  logic [5:0] first_sv = 6'd0;
  logic first_instr = 1'b0;

  initial begin
    slv_ready = '0;
    slv_rdata = '0;
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < 6; i++) slv_rdata[32*i +: 32] = $urandom;
      if (slv_valid == 6'd0) begin
        on_cnt = 0;
        slv_ready = 6'($urandom);
      end else begin
        // Noise on unselected ready lines must be ignored.
        slv_ready = 6'($urandom) & ~slv_valid;
        if (on_cnt == 0) begin
          cur_idx = ref_slave(slv_addr);
          check("slv_valid_decode", {26'd0, slv_valid}, (cur_idx < 0) ? 32'd0 : (32'd1 << cur_idx));
          first_sv = slv_valid; first_instr = slv_instr;
          glog = {glog[6:0], slv_instr}; gcnt++;
          if (slv_instr) begin
            check("slv_addr_fetch", slv_addr, req_i_addr);
            check("slv_wstrb_fetch", {28'd0, slv_wstrb}, 32'd0);
          end else begin
            check("slv_addr_data", slv_addr, req_d_addr);
            check("slv_wdata_data", slv_wdata, req_d_wdata);
            check("slv_wstrb_data", {28'd0, slv_wstrb}, {28'd0, req_d_wstrb});
          end
        end
        busy_cycles++;
        if (cur_idx >= 0 && !ref_hung(slv_addr) && on_cnt == ref_lat(slv_addr)) begin
          slv_ready = slv_ready | slv_valid;
          slv_rdata[32*cur_idx +: 32] = ref_data(slv_addr);
        end
        on_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (imem_ready) begin
        if (q_i.size() == 0) begin
          total++; bad++;
          $display("FAIL imem_spurious: imem_ready=1 with no fetch outstanding, required 0");
        end else begin
          e = q_i.pop_front();
          check("imem_rdata", imem_rdata, e.rdata);
          check("imem_error", {31'd0, imem_error}, {31'd0, e.err});
        end
      end
      if (dmem_ready) begin
        if (q_d.size() == 0) begin
          total++; bad++;
          $display("FAIL dmem_spurious: dmem_ready=1 with no data request outstanding, required 0");
        end else begin
          e = q_d.pop_front();
          check("dmem_rdata", dmem_rdata, e.rdata);
          check("dmem_error", {31'd0, dmem_error}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_slv_valid"}, {26'd0, slv_valid}, 32'd0);
    check({tag, "_slv_req"}, {27'd0, slv_instr, slv_wstrb}, 32'd0);
    check({tag, "_slv_addr"}, slv_addr, 32'd0);
    check({tag, "_slv_wdata"}, slv_wdata, 32'd0);
    check({tag, "_ready_error"}, {28'd0, imem_ready, imem_error, dmem_ready, dmem_error}, 32'd0);
    check({tag, "_rdata"}, imem_rdata | dmem_rdata, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, c2, b0;
    logic [31:0] bnd [8];
    bnd = '{32'h1000003, 32'h1000004, 32'h200BFFF, 32'h7F, 32'h80, 32'h8FFFFFFF, 32'h90000000, 32'h2FFFFFF};
    imem_valid = 0; imem_addr = 0;
    dmem_valid = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    req_i_addr = 0; req_d_addr = 0; req_d_wdata = 0; req_d_wstrb = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    check_quiet("reset");
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Fetch only, RAM.
    drive_i(32'h80000010, cyc);
    check("fetch_cycles", cyc, ref_cycles(32'h80000010));
    check("fetch_slv_valid", {26'd0, first_sv}, 32'h20);
    check("fetch_slv_instr", {31'd0, first_instr}, 32'd1);

    // Contention, last grant was the fetch port: data first.
    gcnt = 0;
    fork
      drive_i(32'h80000000, cyc);
      drive_d(32'h80000004, 32'h12345678, 4'hF, c2);
    join
    check("pair1_count", gcnt, 2);
    check("pair1_order", {30'd0, glog[1:0]}, 32'b01);

    // Data reasserts back-to-back while fetch waits: D, I, D.
    gcnt = 0;
    fork
      begin drive_d(32'h80000008, 32'hA5A5A5A5, 4'h3, c2); drive_d(32'h8000000C, 32'h0, 4'h0, c2); end
      drive_i(32'h80000014, cyc);
    join
    check("pair2_count", gcnt, 3);
    check("pair2_order", {29'd0, glog[2:0]}, 32'b010);

    // Last grant was data: fetch first.
    gcnt = 0;
    fork
      drive_i(32'h80000018, cyc);
      drive_d(32'h8000001C, 32'hCAFEF00D, 4'h1, c2);
    join
    check("pair3_count", gcnt, 2);
    check("pair3_order", {30'd0, glog[1:0]}, 32'b10);

    // Unmapped.
    b0 = busy_cycles;
    drive_d(32'h00000100, 32'h0, 4'h0, cyc);
    check("unmapped_cycles", cyc, 2);
    check("unmapped_no_slv_valid", busy_cycles - b0, 0);

    // Window boundaries.
    for (int k = 0; k < 8; k++) begin
      b0 = busy_cycles;
      drive_d(bnd[k], 32'h0, 4'h0, cyc);
      check("boundary_cycles", cyc, ref_cycles(bnd[k]));
      check("boundary_busy", busy_cycles - b0, (ref_slave(bnd[k]) < 0) ? 0 : ref_cycles(bnd[k]) - 1);
      if (k == 2) check("clint_top_bit2", {26'd0, first_sv}, 32'h4);
    end

    // Hung slave.
    b0 = busy_cycles;
    drive_d(32'h10000000, 32'h0, 4'h0, cyc);
    check("hung_cycles", cyc, 1 + TO);
    check("hung_busy", busy_cycles - b0, TO);
    check("hung_valid_dropped", {26'd0, slv_valid}, 32'd0);

    // Slave answers in the timeout cycle: normal completion.
    drive_i(32'h03000A00, cyc);
    check("late_ok_cycles", cyc, 1 + TO);

    // Reset in the middle of a RAM access.
    req_i_addr = 32'h80000000; imem_addr = 32'h80000000; imem_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("midbusy_slv_valid", {26'd0, slv_valid}, 32'h20);
    #2 reset = 1'b0;
    #1;
    check_quiet("midbusy_reset");
    imem_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    drive_i(32'h0, cyc);
    check("after_reset_cycles", cyc, ref_cycles(32'h0));
    check("after_reset_instr", {31'd0, first_instr}, 32'd1);

    // Randomised traffic from both masters.
    fork
      begin : rnd_i
        int ci;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          drive_i(rand_addr(), ci);
        end
      end
      begin : rnd_d
        int cd;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
          drive_d(rand_addr(), $urandom, 4'($urandom), cd);
        end
      end
    join
    repeat (4) @(posedge clock);
    check("q_i_drained", q_i.size(), 0);
    check("q_d_drained", q_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
